rr_arb8_mux: RTL

RR_ARB8_MUX -- requirements
Module: rr_arb8_mux

---
 rtl/rr_arb8_mux_if.sv | 24 ++
 rtl/rr_arb8_mux.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rr_arb8_mux_if.sv
// Purpose : bundles the eight-requester arbitration bus (requests, data, grant, mux output).
// Latency : n/a (signal container only).
// Backpressure: n/a; the requester holds req[i] high to keep its grant alive.
// Ports   : master = requester side (drives req/w, observes grant and mux output),
//           slave  = arbiter side (observes req/w, drives gnt/sel/out/valid/busy).
interface rr_arb8_mux_if;
  logic [7:0] req;
  logic [7:0] w;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out;
  logic       valid;
  logic       busy;

  modport master (
    output req, w,
    input  gnt, sel, out, valid, busy
  );

  modport slave (
    input  req, w,
    output gnt, sel, out, valid, busy
  );
endinterface

// File: rtl/rr_arb8_mux.sv
// Purpose : 8-way round-robin arbiter feeding a shared 1-bit line through an 8:1 mux, up to BURST bits per grant.
// Latency : grant registered 1 cycle after req is sampled; each transferred bit appears 1 cycle after its edge.
// Backpressure: dropping req[sel] ends the grant on the next edge with no transfer; one idle cycle separates grants.
// Ports   : clk (sole clock), rst (sync active-high), bus (rr_arb8_mux_if.slave):
//           req/w in, gnt/sel/out/valid registered out, busy = grant currently held.
module rr_arb8_mux #(
  parameter int unsigned BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_arb8_mux_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Transfer count value at which the current transfer is the last of the burst.
  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [7:0] gnt_q,   gnt_d;
  logic [2:0] sel_q,   sel_d;
  logic       out_q,   out_d;
  logic       valid_q, valid_d;

  logic       found;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       release_grant;

  // Rotating priority search: first requester at or after ptr, wrapping at 8.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    out_d         = out_q;
    valid_d       = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 8'd1 << pick;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (bus.req[sel_q]) begin
          out_d   = bus.w[sel_q];
          valid_d = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            release_grant = 1'b1;
          end
        end else begin
          release_grant = 1'b1;
        end
        // Going back to IDLE (rather than re-arbitrating here) guarantees the
        // one-cycle gap between grants; sel keeps the last granted index.
        if (release_grant) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          ptr_d   = sel_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == GRANT);

endmodule
